// File: rtl/vgpr_wfid_done_queue.sv
// Completion-event FIFO between the VGPR write-port wfid mux and the issue stage.
// Presents the head event with a one-hot wavefront decode and keeps sticky error flags.
module vgpr_wfid_done_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int NUM_WF = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              muxed_wfid_done,
    input  logic [5:0]        muxed_wfid,
    output logic              done_valid,
    output logic [5:0]        done_wfid,
    output logic [NUM_WF-1:0] done_wfid_onehot,
    input  logic              done_ack,
    output logic [PTR_W:0]    queue_count,
    output logic              queue_full,
    output logic              overflow_err,
    output logic              bad_wfid_err
);

    typedef enum logic {
        EMPTY,
        NONEMPTY
    } state_t;

    localparam logic [6:0]     NUM_WF_L = 7'(NUM_WF);
    localparam logic [PTR_W:0] DEPTH_L  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_L    = (PTR_W+1)'(1);

    state_t           state, state_nxt;
    logic [5:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic             wfid_ok, push_req, push, pop, drop;

    assign wfid_ok  = ({1'b0, muxed_wfid} < NUM_WF_L);
    assign push_req = muxed_wfid_done && wfid_ok;
    assign pop      = done_ack && (count != '0);
    // A full queue still accepts a push when the same-cycle pop frees the head slot.
    assign push     = push_req && ((count != DEPTH_L) || pop);
    assign drop     = push_req && (count == DEPTH_L) && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
            bad_wfid_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + ONE_L;
            else if (pop && !push)
                count <= count - ONE_L;
            if (drop) overflow_err <= 1'b1;
            if (muxed_wfid_done && !wfid_ok) bad_wfid_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= muxed_wfid;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:    if (push) state_nxt = NONEMPTY;
            NONEMPTY: if (pop && !push && (count == ONE_L)) state_nxt = EMPTY;
            default:  state_nxt = EMPTY;
        endcase
    end

    assign done_valid  = (count != '0);
    assign done_wfid   = done_valid ? mem[rd_ptr] : '0;
    assign queue_count = count;
    assign queue_full  = (count == DEPTH_L);

    always_comb begin
        done_wfid_onehot = '0;
        for (int unsigned k = 0; k < NUM_WF; k++) begin
            done_wfid_onehot[k] = done_valid && (done_wfid == 6'(k));
        end
    end

endmodule

// File: tb/tb_vgpr_wfid_done_queue.sv
// Bench for vgpr_wfid_done_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vgpr_wfid_done_queue;

    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;
    localparam int NUM_WF = 40;

    logic              clk = 1'b0;
    logic              rst;
    logic              muxed_wfid_done;
    logic [5:0]        muxed_wfid;
    logic              done_valid;
    logic [5:0]        done_wfid;
    logic [NUM_WF-1:0] done_wfid_onehot;
    logic              done_ack;
    logic [PTR_W:0]    queue_count;
    logic              queue_full;
    logic              overflow_err;
    logic              bad_wfid_err;

    int checks   = 0;
    int failures = 0;

    vgpr_wfid_done_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .NUM_WF(NUM_WF)) dut (
        .clk              (clk),
        .rst              (rst),
        .muxed_wfid_done  (muxed_wfid_done),
        .muxed_wfid       (muxed_wfid),
        .done_valid       (done_valid),
        .done_wfid        (done_wfid),
        .done_wfid_onehot (done_wfid_onehot),
        .done_ack         (done_ack),
        .queue_count      (queue_count),
        .queue_full       (queue_full),
        .overflow_err     (overflow_err),
        .bad_wfid_err     (bad_wfid_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of pending wfids plus two sticky flags.
    int q[$];
    bit m_ovf, m_bad, model_init;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_bad = 1'b0;
            model_init = 1'b1;
        end else begin
            bit pop_ok;
            pop_ok = done_ack && (q.size() > 0);
            if (pop_ok) void'(q.pop_front());
            if (muxed_wfid_done) begin
                if (int'(muxed_wfid) >= NUM_WF) m_bad = 1'b1;
                else if (q.size() >= DEPTH) m_ovf = 1'b1;
                else q.push_back(int'(muxed_wfid));
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) assert (!$isunknown(muxed_wfid_done))
            else $error("muxed_wfid_done is X outside reset");
    end

    always @(negedge clk) begin
        if (model_init) begin
            logic [63:0] e_wfid, e_oh;
            e_wfid = (q.size() > 0) ? 64'(q[0]) : 64'd0;
            e_oh   = (q.size() > 0) ? (64'd1 << q[0]) : 64'd0;
            chk("valid", 64'(done_valid), 64'(q.size() > 0));
            chk("wfid", 64'(done_wfid), e_wfid);
            chk("onehot", 64'(done_wfid_onehot), e_oh);
            chk("count", 64'(queue_count), 64'(q.size()));
            chk("full", 64'(queue_full), 64'(q.size() == DEPTH));
            chk("ovf", 64'(overflow_err), 64'(m_ovf));
            chk("bad", 64'(bad_wfid_err), 64'(m_bad));
        end
    end

    // Drive one cycle of inputs (called at a falling edge), then wait past the next rising edge.
    task automatic cyc(input logic d, input logic [5:0] w, input logic a);
        muxed_wfid_done = d;
        muxed_wfid      = w;
        done_ack        = a;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 6'd0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] oh17;
        int ack_pct;
        rst = 1'b1;
        muxed_wfid_done = 1'b0;
        muxed_wfid = '0;
        done_ack = 1'b0;
        @(negedge clk);
        cyc(1'b0, 6'd0, 1'b0);
        rst = 1'b0;
        chk("lit_reset_valid", 64'(done_valid), 64'd0);
        chk("lit_reset_count", 64'(queue_count), 64'd0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 6'd0, 1'b0);
        chk("lit_idle_onehot", 64'(done_wfid_onehot), 64'd0);
        chk("lit_idle_errs", 64'({overflow_err, bad_wfid_err}), 64'd0);

        // Single event, one cycle latency.
        cyc(1'b1, 6'd17, 1'b0);
        oh17 = 64'd1 << 17;
        chk("lit_single_wfid", 64'(done_wfid), 64'd17);
        chk("lit_single_onehot", 64'(done_wfid_onehot), oh17);
        chk("lit_single_count", 64'(queue_count), 64'd1);
        cyc(1'b0, 6'd0, 1'b1);
        chk("lit_single_popped", 64'(done_valid), 64'd0);

        // Fill then overflow.
        for (int i = 1; i <= 4; i++) cyc(1'b1, 6'(i), 1'b0);
        cyc(1'b1, 6'd5, 1'b0);
        chk("lit_full", 64'(queue_full), 64'd1);
        chk("lit_ovf", 64'(overflow_err), 64'd1);
        chk("lit_full_count", 64'(queue_count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("lit_drain", 64'(done_wfid), 64'(i));
            cyc(1'b0, 6'd0, 1'b1);
        end
        chk("lit_drained", 64'(done_valid), 64'd0);

        // Full queue with simultaneous push and pop.
        do_reset();
        for (int i = 1; i <= 4; i++) cyc(1'b1, 6'(i), 1'b0);
        cyc(1'b1, 6'd9, 1'b1);
        chk("lit_pp_ovf", 64'(overflow_err), 64'd0);
        chk("lit_pp_count", 64'(queue_count), 64'd4);
        chk("lit_pp_head", 64'(done_wfid), 64'd2);
        cyc(1'b0, 6'd0, 1'b1);
        chk("lit_pp_3", 64'(done_wfid), 64'd3);
        cyc(1'b0, 6'd0, 1'b1);
        chk("lit_pp_4", 64'(done_wfid), 64'd4);
        cyc(1'b0, 6'd0, 1'b1);
        chk("lit_pp_9", 64'(done_wfid), 64'd9);
        cyc(1'b0, 6'd0, 1'b1);

        // Pointer wrap.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 6'(i), 1'b0);
            chk("lit_wrap_head", 64'(done_wfid), 64'(i));
            cyc(1'b0, 6'd0, 1'b1);
            chk("lit_wrap_count", 64'(queue_count), 64'd0);
        end

        // Bad wfid, then reset with pending push and pop.
        cyc(1'b1, 6'd45, 1'b0);
        chk("lit_bad", 64'(bad_wfid_err), 64'd1);
        chk("lit_bad_count", 64'(queue_count), 64'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 6'(20 + i), 1'b0);
        chk("lit_three", 64'(queue_count), 64'd3);
        rst = 1'b1;
        cyc(1'b1, 6'd7, 1'b1);
        rst = 1'b0;
        chk("lit_rst_count", 64'(queue_count), 64'd0);
        chk("lit_rst_valid", 64'(done_valid), 64'd0);
        chk("lit_rst_errs", 64'({overflow_err, bad_wfid_err}), 64'd0);

        // Randomized traffic with shifting ack bias to visit empty, full and overflow.
        ack_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) ack_pct = $urandom_range(10, 90);
            rst = ($urandom_range(0, 399) == 0);
            cyc(($urandom_range(0, 99) < 60), 6'($urandom_range(0, 44)),
                ($urandom_range(0, 99) < ack_pct));
        end
        rst = 1'b0;
        cyc(1'b0, 6'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
